// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types and constants.
// Used by the fetch stage and its instruction buffer.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous instruction buffer of fetch_entry_t.
// Flush wins over push; a push into a full FIFO is only taken with a pop.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);

  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    empty   = (cnt_q == '0);
    full    = (cnt_q == FULL_C);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d = wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + {{AW{1'b0}}, do_push}
                    - {{AW{1'b0}}, do_pop};
    end
    dout  = mem_q[rd_q];
    count = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC, imem req/gnt/rvalid, buffer to IF/ID.
// Define FETCH_BYPASS_EN to forward a response straight to IF/ID when empty.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_f,
  output logic [31:0] pc_f,
  output logic [31:0] inst_f
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 2;
  localparam logic [NW-1:0] MAX_N = NW'(MAX_OUTSTANDING);
  localparam logic [NW-1:0] DEP_N = NW'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [NW-1:0] out_q, out_d;
  logic [NW-1:0] drop_q, drop_d;

  fetch_entry_t  wr_ent, head;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty, fifo_full;
  logic          push, pop;
  logic [31:0]   tgt;
  logic [NW-1:0] cnt_n;
  logic          rsp, keep, byp, credit, fire;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (wr_ent),
    .dout  (head),
    .count (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    tgt    = word_align(redirect_pc);
    cnt_n  = {1'b0, fifo_cnt};
    rsp    = imem_rvalid && (out_q != '0);
    keep   = rsp && (drop_q == '0) && !redirect;
    pop    = !fifo_empty && !stall && !redirect;
`ifdef FETCH_BYPASS_EN
    byp    = fifo_empty && keep;
`else
    byp    = 1'b0;
`endif
    push   = keep && !(byp && !stall);
    wr_ent = '{pc: resp_pc_q, inst: imem_rdata};

    // A slot freed by this cycle's pop is usable by a response
    // that can only arrive next cycle or later.
    credit = (out_q < MAX_N) &&
             ((out_q + cnt_n - {{(NW-1){1'b0}}, pop}) < DEP_N);
    imem_req  = credit && !rst;
    imem_addr = fetch_pc_q;
    fire      = imem_req && imem_gnt;

    out_d = out_q + {{(NW-1){1'b0}}, fire}
                  - {{(NW-1){1'b0}}, rsp};

    if (redirect) begin
      fetch_pc_d = tgt;
      resp_pc_d  = tgt;
      // everything still in flight after this cycle is wrong-path
      drop_d     = out_d;
    end else begin
      fetch_pc_d = fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
      resp_pc_d  = keep ? resp_pc_q + 32'd4 : resp_pc_q;
      drop_d     = (rsp && drop_q != '0) ? drop_q - 1'b1 : drop_q;
    end

    valid_f = !fifo_empty || byp;
    if (!fifo_empty) begin
      pc_f   = head.pc;
      inst_f = head.inst;
    end else if (byp) begin
      pc_f   = resp_pc_q;
      inst_f = imem_rdata;
    end else begin
      pc_f   = '0;
      inst_f = NOP_INST;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  a_rvalid_expected: assert property (
    @(posedge clk) disable iff (rst)
    imem_rvalid |-> (out_q != '0)
  );

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    (push && fifo_full && !redirect) |-> pop
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory responder plus a stream-level
// model of which PC must reach IF/ID next and which address is fetched next.
module tb_fetch_unit;
  import rv32i_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        valid_f;
  logic [31:0] pc_f, inst_f;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .valid_f     (valid_f),
    .pc_f        (pc_f),
    .inst_f      (inst_f)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] pend_addr[$];
  int          pend_rdy[$];
  int          k;
  int          gnt_mode;
  int          lat_max;
  bit          hold, stall_v, redir_v;
  logic [31:0] redir_tgt;
  logic [31:0] exp_pc, exp_fetch;
  int          consumed;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // One clock: drive at negedge, sample 1 ns later, update model.
  task automatic cycle();
    @(negedge clk);
    if (gnt_mode == 0)      imem_gnt = 1'b0;
    else if (gnt_mode == 1) imem_gnt = 1'b1;
    else                    imem_gnt = ($urandom_range(0, 2) != 0);
    imem_rvalid = !hold && (pend_addr.size() > 0) && (pend_rdy[0] <= k);
    imem_rdata  = imem_rvalid ? mem_of(pend_addr[0]) : $urandom;
    stall       = stall_v;
    redirect    = redir_v;
    redirect_pc = redir_tgt;
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = valid_f;
    s_pc    = pc_f;
    s_inst  = inst_f;
    if (s_valid) begin
      total++;
      if (s_pc !== exp_pc) begin
        bad++;
        $display("FAIL head_pc k=%0d got=%h exp=%h", k, s_pc, exp_pc);
      end
      total++;
      if (s_inst !== mem_of(exp_pc)) begin
        bad++;
        $display("FAIL head_inst k=%0d got=%h exp=%h",
                 k, s_inst, mem_of(exp_pc));
      end
    end else begin
      total++;
      if (s_pc !== 32'h0 || s_inst !== NOP) begin
        bad++;
        $display("FAIL idle_out k=%0d got pc=%h inst=%h exp pc=0 inst=%h",
                 k, s_pc, s_inst, NOP);
      end
    end
    if (s_valid && !stall_v && !redir_v) begin
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (imem_rvalid) begin
      void'(pend_addr.pop_front());
      void'(pend_rdy.pop_front());
    end
    if (s_req && imem_gnt) begin
      total++;
      if (s_addr !== exp_fetch) begin
        bad++;
        $display("FAIL fetch_addr k=%0d got=%h exp=%h", k, s_addr, exp_fetch);
      end
      pend_addr.push_back(s_addr);
      pend_rdy.push_back(k + 1 + $urandom_range(0, lat_max));
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redir_v) begin
      exp_pc    = redir_tgt & 32'hFFFF_FFFC;
      exp_fetch = redir_tgt & 32'hFFFF_FFFC;
    end
    k++;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    gnt_mode    = 0;
    lat_max     = 0;
    hold        = 1'b0;
    stall_v     = 1'b0;
    redir_v     = 1'b0;
    redir_tgt   = '0;
    pend_addr.delete();
    pend_rdy.delete();
    exp_pc      = 32'h0;
    exp_fetch   = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k   = 0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_req got=%b exp=0", imem_req);
    end
    total++;
    if (imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL rst_addr got=%h exp=0", imem_addr);
    end
    total++;
    if (valid_f !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b exp=0", valid_f);
    end
    total++;
    if (pc_f !== 32'h0 || inst_f !== NOP) begin
      bad++;
      $display("FAIL rst_out got pc=%h inst=%h exp pc=0 inst=%h",
               pc_f, inst_f, NOP);
    end
  endtask

  task automatic test_stream();
    do_reset();
    gnt_mode = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      total++;
      if (s_req !== 1'b1 || s_addr !== 32'(4 * i)) begin
        bad++;
        $display("FAIL stream_req i=%0d got req=%b addr=%h exp req=1 addr=%h",
                 i, s_req, s_addr, 32'(4 * i));
      end
      total++;
      if (s_valid !== (i >= LAT)) begin
        bad++;
        $display("FAIL stream_valid i=%0d got=%b exp=%b",
                 i, s_valid, (i >= LAT));
      end
      if (i >= LAT) begin
        total++;
        if (s_pc !== 32'(4 * (i - LAT))) begin
          bad++;
          $display("FAIL stream_pc i=%0d got=%h exp=%h",
                   i, s_pc, 32'(4 * (i - LAT)));
        end
      end
    end
  endtask

  task automatic test_stall();
    int c0;
    stall_v = 1'b1;
    repeat (3) cycle();
    total++;
    if (s_req !== 1'b0) begin
      bad++;
      $display("FAIL stall_req got=%b exp=0", s_req);
    end
    total++;
    if (s_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_valid got=%b exp=1", s_valid);
    end
    stall_v = 1'b0;
    c0 = consumed;
    repeat (10) cycle();
    total++;
    if (consumed - c0 < 8) begin
      bad++;
      $display("FAIL stall_resume got=%0d exp>=8", consumed - c0);
    end
  endtask

  task automatic test_redirect_drop();
    bit found;
    do_reset();
    gnt_mode = 1;
    hold     = 1'b1;
    repeat (2) cycle();
    redir_v   = 1'b1;
    redir_tgt = 32'h0000_0100;
    cycle();
    total++;
    if (s_req !== 1'b0) begin
      bad++;
      $display("FAIL rd_full_req got=%b exp=0", s_req);
    end
    redir_v = 1'b0;
    hold    = 1'b0;
    cycle();
    total++;
    if (s_addr !== 32'h100 || s_req !== 1'b0 || s_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_after got addr=%h req=%b valid=%b exp 100/0/0",
               s_addr, s_req, s_valid);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = s_valid;
    end
    total++;
    if (!found || s_pc !== 32'h100) begin
      bad++;
      $display("FAIL rd_first_pc got found=%b pc=%h exp pc=100", found, s_pc);
    end
  endtask

  task automatic test_redirect_stall_grant();
    bit found;
    do_reset();
    gnt_mode = 1;
    stall_v  = 1'b1;
    cycle();
    total++;
    if (s_req !== 1'b1) begin
      bad++;
      $display("FAIL rsg_req0 got=%b exp=1", s_req);
    end
    gnt_mode = 0;
    cycle();
    gnt_mode  = 1;
    redir_v   = 1'b1;
    redir_tgt = 32'h0000_0200;
    cycle();
    total++;
    if (s_req !== 1'b1 || s_valid !== 1'b1) begin
      bad++;
      $display("FAIL rsg_redir got req=%b valid=%b exp 1/1", s_req, s_valid);
    end
    redir_v = 1'b0;
    stall_v = 1'b0;
    cycle();
    total++;
    if (s_valid !== 1'b0 || s_addr !== 32'h200) begin
      bad++;
      $display("FAIL rsg_flush got valid=%b addr=%h exp 0/200",
               s_valid, s_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = s_valid;
    end
    total++;
    if (!found || s_pc !== 32'h200) begin
      bad++;
      $display("FAIL rsg_first_pc got found=%b pc=%h exp pc=200", found, s_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_mode  = 0;
    redir_v   = 1'b1;
    redir_tgt = 32'hFFFF_FFFE;
    cycle();
    redir_v  = 1'b0;
    gnt_mode = 1;
    cycle();
    total++;
    if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_top got req=%b addr=%h exp 1/fffffffc",
               s_req, s_addr);
    end
    cycle();
    total++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap_zero got req=%b addr=%h exp 1/0", s_req, s_addr);
    end
    repeat (6) cycle();
  endtask

  task automatic test_random();
    int c0;
    do_reset();
    gnt_mode = 2;
    lat_max  = 3;
    c0 = consumed;
    for (int i = 0; i < 3000; i++) begin
      stall_v   = ($urandom_range(0, 3) == 0);
      redir_v   = ($urandom_range(0, 39) == 0);
      redir_tgt = $urandom;
      cycle();
    end
    stall_v = 1'b0;
    redir_v = 1'b0;
    total++;
    if (consumed - c0 < 300) begin
      bad++;
      $display("FAIL rand_progress got=%0d exp>=300", consumed - c0);
    end
  endtask

  initial begin
    consumed = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_stall_grant();
    test_wrap();
    test_random();
    test_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
